// File: rtl/dm_load_unit_if.sv
// Pipeline-side load request/response and data-memory read handshake for dm_load_unit.
// The unit uses the slave view; the surrounding pipeline/memory (or a bench) uses the master view.
interface dm_load_unit_if;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_instr;
    logic [31:0] ld_addr;
    logic        flush;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        ld_done;
    logic [31:0] ld_data;
    logic        ld_exc;
    logic [4:0]  ld_exccode;
    logic [31:0] ld_badaddr;

    modport slave (
        input  ld_valid, ld_instr, ld_addr, flush, mem_ack, mem_rdata,
        output ld_ready, mem_req, mem_addr, ld_done, ld_data, ld_exc, ld_exccode, ld_badaddr
    );

    modport master (
        output ld_valid, ld_instr, ld_addr, flush, mem_ack, mem_rdata,
        input  ld_ready, mem_req, mem_addr, ld_done, ld_data, ld_exc, ld_exccode, ld_badaddr
    );
endinterface

// File: rtl/dm_load_unit.sv
// Data-memory load unit: one word-aligned read per load over a variable-latency req/ack
// handshake, byte/halfword extraction with sign/zero extension, AdEL and DBE exceptions.
module dm_load_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    dm_load_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_ERR
    } state_e;

    typedef enum logic [5:0] {
        OP_LB  = 6'b100000,
        OP_LH  = 6'b100001,
        OP_LW  = 6'b100011,
        OP_LBU = 6'b100100,
        OP_LHU = 6'b100101
    } opcode_e;

    localparam logic [4:0]  EXC_ADEL = 5'd4;
    localparam logic [4:0]  EXC_DBE  = 5'd7;
    localparam int unsigned CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e      state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        kill_q, kill_d;
    logic [31:0] data_q, data_d;
    logic [4:0]  code_q, code_d;

    logic [5:0]  in_op;
    logic        timeout_hit;
    logic        kill_now;

    function automatic logic is_load(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: is_load = 1'b1;
            default:                             is_load = 1'b0;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] lo);
        case (op)
            OP_LH, OP_LHU: is_misaligned = lo[0];
            OP_LW:         is_misaligned = (lo != 2'b00);
            default:       is_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [5:0] op, input logic [1:0] lo,
                                            input logic [31:0] word);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        case (lo)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
        half_v = lo[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LB:   extract = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  extract = {24'h0, byte_v};
            OP_LH:   extract = {{16{half_v[15]}}, half_v};
            OP_LHU:  extract = {16'h0, half_v};
            default: extract = word;
        endcase
    endfunction

    assign in_op       = bus.ld_instr[31:26];
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
    // A flush arriving in the same cycle as the ack/timeout must also swallow the response.
    assign kill_now    = kill_q | bus.flush;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        kill_d  = kill_q;
        data_d  = data_q;
        code_d  = code_q;

        case (state_q)
            S_IDLE: begin
                kill_d = 1'b0;
                if (bus.ld_valid && !bus.flush && is_load(in_op)) begin
                    op_d   = in_op;
                    addr_d = bus.ld_addr;
                    cnt_d  = '0;
                    if (is_misaligned(in_op, bus.ld_addr[1:0])) begin
                        code_d  = EXC_ADEL;
                        state_d = S_ERR;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end

            S_REQ: begin
                if (bus.flush) begin
                    kill_d = 1'b1;
                end
                // Ack has priority over a timeout landing in the same cycle.
                if (bus.mem_ack) begin
                    kill_d = 1'b0;
                    if (kill_now) begin
                        state_d = S_IDLE;
                    end else begin
                        data_d  = extract(op_q, addr_q[1:0], bus.mem_rdata);
                        state_d = S_RESP;
                    end
                end else if (timeout_hit) begin
                    kill_d = 1'b0;
                    if (kill_now) begin
                        state_d = S_IDLE;
                    end else begin
                        code_d  = EXC_DBE;
                        state_d = S_ERR;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_RESP:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            kill_q  <= 1'b0;
            data_q  <= '0;
            code_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge value of the others.
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            kill_q  <= kill_d;
            data_q  <= data_d;
            code_q  <= code_d;
        end
    end

    assign bus.ld_ready   = (state_q == S_IDLE);
    assign bus.mem_req    = (state_q == S_REQ);
    assign bus.mem_addr   = {addr_q[31:2], 2'b00};
    assign bus.ld_done    = (state_q == S_RESP) && !bus.flush;
    assign bus.ld_exc     = (state_q == S_ERR) && !bus.flush;
    assign bus.ld_data    = data_q;
    assign bus.ld_exccode = code_q;
    assign bus.ld_badaddr = addr_q;

endmodule

// File: tb/tb_dm_load_unit.sv
// Scoreboard bench for dm_load_unit: stimulus pushes expected responses, a negedge
// monitor pops and compares them whenever ld_done or ld_exc pulses.
module tb_dm_load_unit;

    localparam int TIMEOUT = 16;

    localparam logic [5:0] LB  = 6'b100000;
    localparam logic [5:0] LH  = 6'b100001;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] LBU = 6'b100100;
    localparam logic [5:0] LHU = 6'b100101;

    typedef struct {
        logic        exc;
        logic [31:0] data;
        logic [4:0]  code;
        logic [31:0] bad;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    dm_load_unit_if bus ();

    dm_load_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic exp_t mk_done(input logic [31:0] data);
        exp_t e;
        e = '{exc: 1'b0, data: data, code: 5'd0, bad: 32'h0};
        return e;
    endfunction

    function automatic exp_t mk_exc(input logic [4:0] code, input logic [31:0] bad);
        exp_t e;
        e = '{exc: 1'b1, data: 32'h0, code: code, bad: bad};
        return e;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.ld_done === 1'b1 || bus.ld_exc === 1'b1) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_pulse: got done=%0b exc=%0b, expected no response",
                             bus.ld_done, bus.ld_exc);
                end else begin
                    e = sb.pop_front();
                    check("resp_kind", {30'h0, bus.ld_done, bus.ld_exc}, {30'h0, ~e.exc, e.exc});
                    if (e.exc) begin
                        check("ld_exccode", {27'h0, bus.ld_exccode}, {27'h0, e.code});
                        check("ld_badaddr", bus.ld_badaddr, e.bad);
                    end else begin
                        check("ld_data", bus.ld_data, e.data);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Issue one load and play the memory side. ack_cycle/flush_cycle count REQ cycles
    // from 1; 0 means never. exp_req is the expected number of cycles mem_req stays high.
    task automatic run_load(input string tag, input logic [5:0] op, input logic [31:0] addr,
                            input logic [31:0] rdata, input int ack_cycle, input int flush_cycle,
                            input int exp_req, input logic exp_resp, input exp_t e);
        int req_cycles;
        req_cycles = 0;
        if (exp_resp) sb.push_back(e);
        check({tag, "_ready_in"}, {31'h0, bus.ld_ready}, 32'h1);
        bus.ld_valid = 1'b1;
        bus.ld_instr = {op, 26'h0};
        bus.ld_addr  = addr;
        @(posedge clk); #1;
        bus.ld_valid = 1'b0;
        bus.ld_instr = '0;
        bus.ld_addr  = '0;
        for (int n = 1; n <= 40 && bus.mem_req === 1'b1; n++) begin
            req_cycles++;
            check({tag, "_mem_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
            bus.mem_ack   = (n == ack_cycle);
            bus.mem_rdata = (n == ack_cycle) ? rdata : 32'hDEAD_BEEF;
            bus.flush     = (n == flush_cycle);
            @(posedge clk); #1;
        end
        bus.mem_ack = 1'b0;
        bus.flush   = 1'b0;
        check({tag, "_req_cycles"}, req_cycles, exp_req);
        check({tag, "_ready_after"}, {31'h0, bus.ld_ready}, {31'h0, ~exp_resp});
        @(posedge clk); #1;
        check({tag, "_ready_idle"}, {31'h0, bus.ld_ready}, 32'h1);
    endtask

    initial begin : stimulus
        reset         = 1'b1;
        bus.ld_valid  = 1'b0;
        bus.ld_instr  = '0;
        bus.ld_addr   = '0;
        bus.flush     = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_ready",   {31'h0, bus.ld_ready}, 32'h1);
        check("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
        check("rst_pulses",  {30'h0, bus.ld_done, bus.ld_exc}, 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_ld_data",  bus.ld_data, 32'h0);
        check("rst_exccode",  {27'h0, bus.ld_exccode}, 32'h0);
        check("rst_badaddr",  bus.ld_badaddr, 32'h0);

        // Byte loads from word 0x80FF1234 at 0x1000.
        run_load("lb3",  LB,  32'h1003, 32'h80FF1234, 1, 0, 1, 1'b1, mk_done(32'hFFFFFF80));
        run_load("lbu3", LBU, 32'h1003, 32'h80FF1234, 3, 0, 3, 1'b1, mk_done(32'h00000080));
        run_load("lb0",  LB,  32'h1000, 32'h80FF1234, 2, 0, 2, 1'b1, mk_done(32'h00000034));
        run_load("lbu1", LBU, 32'h1001, 32'h80FF1234, 1, 0, 1, 1'b1, mk_done(32'h00000012));
        run_load("lb2",  LB,  32'h1002, 32'h80FF1234, 1, 0, 1, 1'b1, mk_done(32'hFFFFFFFF));

        // Halfword and word loads from 0x80017FFF at 0x2000.
        run_load("lh2",  LH,  32'h2002, 32'h80017FFF, 1, 0, 1, 1'b1, mk_done(32'hFFFF8001));
        run_load("lhu2", LHU, 32'h2002, 32'h80017FFF, 4, 0, 4, 1'b1, mk_done(32'h00008001));
        run_load("lh0",  LH,  32'h2000, 32'h80017FFF, 1, 0, 1, 1'b1, mk_done(32'h00007FFF));
        run_load("lw0",  LW,  32'h2000, 32'h80017FFF, 2, 0, 2, 1'b1, mk_done(32'h80017FFF));

        // Misaligned: exception, no memory access.
        run_load("lw_mis",  LW,  32'h1002, 32'h0, 0, 0, 0, 1'b1, mk_exc(5'd4, 32'h1002));
        run_load("lh_mis",  LH,  32'h1001, 32'h0, 0, 0, 0, 1'b1, mk_exc(5'd4, 32'h1001));
        run_load("lhu_mis", LHU, 32'h1003, 32'h0, 0, 0, 0, 1'b1, mk_exc(5'd4, 32'h1003));

        // Bus timeout, and an ack on the last allowed cycle.
        run_load("lw_to",   LW, 32'h4000, 32'h0, 0, 0, TIMEOUT, 1'b1, mk_exc(5'd7, 32'h4000));
        run_load("lw_late", LW, 32'h4004, 32'h12345678, TIMEOUT, 0, TIMEOUT, 1'b1,
                 mk_done(32'h12345678));

        // Flush in REQ: handshake completes, response swallowed; next load normal.
        run_load("lw_kill", LW, 32'h5000, 32'hAAAA5555, 6, 1, 6, 1'b0, mk_done(32'h0));
        run_load("lw_next", LW, 32'h5004, 32'hCAFEF00D, 2, 0, 2, 1'b1, mk_done(32'hCAFEF00D));

        // Flush in IDLE blocks the accept.
        bus.ld_valid = 1'b1;
        bus.ld_instr = {LW, 26'h0};
        bus.ld_addr  = 32'h2000;
        bus.flush    = 1'b1;
        @(posedge clk); #1;
        bus.ld_valid = 1'b0;
        bus.flush    = 1'b0;
        check("idle_flush_req",   {31'h0, bus.mem_req}, 32'h0);
        check("idle_flush_ready", {31'h0, bus.ld_ready}, 32'h1);

        // Non-load opcode (SW) is ignored.
        bus.ld_valid = 1'b1;
        bus.ld_instr = {6'h2B, 26'h0};
        bus.ld_addr  = 32'h3000;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("nonload_req",   {31'h0, bus.mem_req}, 32'h0);
            check("nonload_ready", {31'h0, bus.ld_ready}, 32'h1);
        end
        bus.ld_valid = 1'b0;

        // Reset while in REQ, then a stray ack that must be ignored.
        bus.ld_valid = 1'b1;
        bus.ld_instr = {LW, 26'h0};
        bus.ld_addr  = 32'h3000;
        @(posedge clk); #1;
        bus.ld_valid = 1'b0;
        check("rstreq_in_req", {31'h0, bus.mem_req}, 32'h1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rstreq_mem_req",  {31'h0, bus.mem_req}, 32'h0);
        check("rstreq_ready",    {31'h0, bus.ld_ready}, 32'h1);
        check("rstreq_mem_addr", bus.mem_addr, 32'h0);
        check("rstreq_ld_data",  bus.ld_data, 32'h0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h5555AAAA;
        repeat (2) @(posedge clk);
        #1 bus.mem_ack = 1'b0;
        check("stray_ack_req",   {31'h0, bus.mem_req}, 32'h0);
        check("stray_ack_ready", {31'h0, bus.ld_ready}, 32'h1);

        repeat (3) @(posedge clk);
        #1 check("sb_drained", sb.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
